// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM encoding, frame
// geometry and default bit-period constants.
package uart_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } uart_state_t;

  localparam int UART_DATA_BITS   = 8;
  localparam int IDX_W            = $clog2(UART_DATA_BITS);
  localparam int CLKS_PER_BIT_HW  = 868;  // 100 MHz / 115200
  localparam int CLKS_PER_BIT_SIM = 4;

  function automatic logic is_last_bit(input logic [IDX_W-1:0] idx);
    return idx == IDX_W'(UART_DATA_BITS - 1);
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte-write and status bundle between the I/O controller and uart_tx.
interface uart_tx_if;
  import uart_pkg::*;

  // Write handshake: wr_en is a strobe qualified by full; a byte is taken on
  // any rising edge where wr_en=1 and full=0, otherwise it is dropped and
  // overflow pulses on the following cycle.
  logic                      wr_en;
  logic [UART_DATA_BITS-1:0] wr_data;
  logic                      full;
  logic                      empty;
  logic                      busy;
  logic                      tx_done;
  logic                      overflow;
  logic                      tx;
  uart_state_t               state;

  modport master (
    output wr_en, wr_data,
    input  full, empty, busy, tx_done, overflow, tx, state
  );

  modport slave (
    input  wr_en, wr_data,
    output full, empty, busy, tx_done, overflow, tx, state
  );

endinterface

// File: rtl/uart_tx_fifo.sv
// Circular-buffer FIFO with an extra pointer MSB to tell full from empty.
// Head entry is presented combinationally on dout.
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_push;
  logic             w_pop;

  // Both qualifiers use pre-edge occupancy, so a write to a full FIFO is
  // dropped even if a pop happens on the same edge.
  assign w_push = push && !full;
  assign w_pop  = pop  && !empty;

  assign full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign empty = (r_wptr == r_rptr);
  assign dout  = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: bytes queue in uart_tx_fifo and are shifted out LSB
// first; frames run back to back while the FIFO has data.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_HW,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  uart_tx_if.slave bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BAUD_ONE  = CW'(1);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  uart_state_t               r_state, w_state_nx;
  logic [CW-1:0]             r_baud, w_baud_nx;
  logic [IDX_W-1:0]          r_idx, w_idx_nx;
  logic [UART_DATA_BITS-1:0] r_shift, w_shift_nx;
  logic                      r_tx, w_tx_nx;
  logic                      r_overflow;
  logic                      w_pop;
  logic                      w_baud_last;
  logic [UART_DATA_BITS-1:0] w_dout;
  logic                      w_full;
  logic                      w_empty;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (bus.wr_en),
    .din   (bus.wr_data),
    .pop   (w_pop),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty)
  );

  assign w_baud_last = (r_baud == BAUD_LAST);

  always_comb begin
    w_state_nx = r_state;
    w_baud_nx  = r_baud;
    w_idx_nx   = r_idx;
    w_shift_nx = r_shift;
    w_tx_nx    = r_tx;
    w_pop      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_tx_nx   = 1'b1;
        w_baud_nx = '0;
        if (!w_empty) begin
          w_pop      = 1'b1;
          w_shift_nx = w_dout;
          w_tx_nx    = 1'b0;
          w_idx_nx   = '0;
          w_state_nx = S_START;
        end
      end
      S_START: begin
        if (w_baud_last) begin
          w_baud_nx  = '0;
          w_tx_nx    = r_shift[0];
          w_idx_nx   = '0;
          w_state_nx = S_DATA;
        end else begin
          w_baud_nx = r_baud + BAUD_ONE;
        end
      end
      S_DATA: begin
        if (w_baud_last) begin
          w_baud_nx  = '0;
          w_shift_nx = r_shift >> 1;
          w_idx_nx   = r_idx + IDX_ONE;
          if (is_last_bit(r_idx)) begin
            w_tx_nx    = 1'b1;
            w_state_nx = S_STOP;
          end else begin
            w_tx_nx = r_shift[1];
          end
        end else begin
          w_baud_nx = r_baud + BAUD_ONE;
        end
      end
      S_STOP: begin
        if (w_baud_last) begin
          w_baud_nx = '0;
          // Chain straight into the next start bit so frames have no idle gap.
          if (!w_empty) begin
            w_pop      = 1'b1;
            w_shift_nx = w_dout;
            w_tx_nx    = 1'b0;
            w_idx_nx   = '0;
            w_state_nx = S_START;
          end else begin
            w_state_nx = S_IDLE;
          end
        end else begin
          w_baud_nx = r_baud + BAUD_ONE;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_tx_nx    = 1'b1;
        w_baud_nx  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_baud     <= '0;
      r_idx      <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_baud     <= w_baud_nx;
      r_idx      <= w_idx_nx;
      r_shift    <= w_shift_nx;
      r_tx       <= w_tx_nx;
      r_overflow <= bus.wr_en && w_full;
    end
  end

  assign bus.full     = w_full;
  assign bus.empty    = w_empty;
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.tx_done  = (r_state == S_STOP) && w_baud_last;
  assign bus.overflow = r_overflow;
  assign bus.tx       = r_tx;
  assign bus.state    = r_state;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a frame-level reference model predicts FIFO occupancy and
// frame timing; a line monitor decodes tx and checks bytes against exp_q.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int C     = CLKS_PER_BIT_SIM;
  localparam int D     = 4;
  localparam int FRAME = 10 * C;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_if bus();

  uart_tx #(
    .CLKS_PER_BIT (C),
    .FIFO_DEPTH   (D)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] m_fifo[$];
  bit         m_active = 1'b0;
  int         m_p = 0;
  int         edge_cnt = 0;
  bit         m_ovf = 1'b0;
  int         ovf_pulses = 0;
  bit         rst_seen = 1'b0;
  bit         mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, compare after it.
  task automatic tick(input bit we, input logic [7:0] d);
    bus.wr_en   = we;
    bus.wr_data = d;
    @(posedge clk);
    edge_cnt++;
    m_ovf = we && (m_fifo.size() == D);
    if (!m_active) begin
      if (m_fifo.size() > 0) begin
        void'(m_fifo.pop_front());
        m_active = 1'b1;
        m_p = edge_cnt;
      end
    end else if (edge_cnt == m_p + FRAME) begin
      if (m_fifo.size() > 0) begin
        void'(m_fifo.pop_front());
        m_p = edge_cnt;
      end else begin
        m_active = 1'b0;
      end
    end
    if (we && !m_ovf) begin
      m_fifo.push_back(d);
      exp_q.push_back(d);
    end
    #1;
    ovf_pulses += int'(bus.overflow);
    check("busy", bus.busy, m_active);
    check("empty", bus.empty, m_fifo.size() == 0);
    check("full", bus.full, m_fifo.size() == D);
    check("overflow", bus.overflow, m_ovf);
    check("tx_done", bus.tx_done, m_active && (edge_cnt == m_p + FRAME - 1));
    if (!m_active) check("tx_idle_high", bus.tx, 1'b1);
  endtask

  task automatic do_reset();
    bus.wr_en = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    edge_cnt++;
    m_fifo.delete();
    exp_q.delete();
    m_active = 1'b0;
    m_ovf = 1'b0;
    rst_seen = 1'b1;
    #1;
    check("rst_tx", bus.tx, 1'b1);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_empty", bus.empty, 1'b1);
    check("rst_full", bus.full, 1'b0);
    check("rst_tx_done", bus.tx_done, 1'b0);
    check("rst_overflow", bus.overflow, 1'b0);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    int guard = 0;
    while ((m_active || m_fifo.size() > 0) && guard < 2000) begin
      tick(1'b0, 8'h00);
      guard++;
    end
    check("drain_timeout", guard < 2000, 1'b1);
    repeat (3) tick(1'b0, 8'h00);
  endtask

  // Line monitor: each frame is 10 bit-slots of C cycles; every cycle is
  // compared to the ideal waveform and the byte is decoded mid-bit.
  initial begin
    bit         act;
    int         off;
    int         shape;
    int         j;
    bit         unexp;
    bit         eb;
    logic [7:0] want;
    logic [7:0] got;
    act = 1'b0;
    off = 0;
    shape = 0;
    unexp = 1'b0;
    want = '0;
    got = '0;
    forever begin
      @(negedge clk);
      if (!mon_en) continue;
      if (rst_seen) begin
        rst_seen = 1'b0;
        act = 1'b0;
        continue;
      end
      if (!act && bus.tx == 1'b0) begin
        act = 1'b1;
        off = 0;
        shape = 0;
        got = '0;
        if (exp_q.size() == 0) begin
          unexp = 1'b1;
          want = '0;
        end else begin
          unexp = 1'b0;
          want = exp_q.pop_front();
        end
      end
      if (act) begin
        j = off / C;
        if (j == 0) eb = 1'b0;
        else if (j == 9) eb = 1'b1;
        else eb = want[j-1];
        if (bus.tx !== eb) shape++;
        if (j >= 1 && j <= 8 && (off % C) == C / 2) got[j-1] = bus.tx;
        off++;
        if (off == FRAME) begin
          act = 1'b0;
          check("frame_unexpected", unexp, 1'b0);
          check("frame_byte", got, want);
          check("frame_shape_errs", shape, 0);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int base;
    bus.wr_en = 1'b0;
    bus.wr_data = 8'h00;
    do_reset();
    do_reset();
    mon_en = 1'b1;

    // Single byte
    tick(1'b1, 8'hA5);
    repeat (45) tick(1'b0, 8'h00);

    // Back-to-back frames
    tick(1'b1, 8'h00);
    tick(1'b1, 8'hFF);
    repeat (85) tick(1'b0, 8'h00);

    // Overflow: six consecutive writes from idle
    base = ovf_pulses;
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, 8'($urandom_range(0, 255)));
      if (i == 4) check("full_after_5th", bus.full, 1'b1);
    end
    drain();
    check("ovf_pulse_count", ovf_pulses - base, 1);

    // Pointer wrap: 12 bytes streamed whenever there is room
    k = 1;
    while (k <= 12) begin
      if (m_fifo.size() < D) begin
        tick(1'b1, 8'(k));
        k++;
      end else begin
        tick(1'b0, 8'h00);
      end
    end
    drain();
    check("wrap_empty_end", bus.empty, 1'b1);

    // Reset during data bit 3 with two bytes queued
    tick(1'b1, 8'h3C);
    tick(1'b1, 8'($urandom_range(0, 255)));
    tick(1'b1, 8'($urandom_range(0, 255)));
    while (edge_cnt < m_p + 4 * C + 1) tick(1'b0, 8'h00);
    do_reset();
    repeat (60) tick(1'b0, 8'h00);

    // Write on the same edge as the STOP->START pop with two bytes queued
    tick(1'b1, 8'($urandom_range(0, 255)));
    tick(1'b1, 8'($urandom_range(0, 255)));
    tick(1'b1, 8'($urandom_range(0, 255)));
    while (edge_cnt + 1 < m_p + FRAME) tick(1'b0, 8'h00);
    tick(1'b1, 8'($urandom_range(0, 255)));
    check("simul_not_empty", bus.empty, 1'b0);
    drain();

    // Random traffic
    repeat (300) begin
      if ($urandom_range(0, 3) == 0) tick(1'b1, 8'($urandom_range(0, 255)));
      else tick(1'b0, 8'h00);
    end
    drain();

    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
